// File: rtl/gray_step_sequencer_pkg.sv
// Shared types and helpers for the Gray-coded step sequencer.
package gray_step_sequencer_pkg;

  localparam int unsigned DEF_WIDTH  = 3;
  localparam int unsigned DEF_STEP_W = 8;
  localparam int unsigned DEF_DLY_W  = 8;

  // Widest position a Gray encoder built on bin_to_gray can handle.
  localparam int unsigned GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Reflected binary Gray code; narrower values are zero-extended by the caller.
  function automatic logic [GRAY_MAX_W-1:0] bin_to_gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_step_sequencer_gray_encoder.sv
// Combinational binary-to-Gray encoder, reusable by any Gray counter.
module gray_encoder
  import gray_step_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // Encode through the shared helper at full width, then trim back.
  always_comb begin
    gray = WIDTH'(bin_to_gray(GRAY_MAX_W'(bin)));
  end

endmodule

// File: rtl/gray_step_sequencer.sv
// Command-driven Gray position sequencer: accepts a move (dir, steps, dwell)
// and walks a binary position one step per dwell period, shown Gray-coded.
module gray_step_sequencer
  import gray_step_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STEP_W = DEF_STEP_W,
  parameter int unsigned DLY_W  = DEF_DLY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [DLY_W-1:0]  cmd_delay,
  input  logic              abort,
  output logic [WIDTH-1:0]  gray,
  output logic              step_strobe,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  state_t              state;
  logic [WIDTH-1:0]    bin;
  logic                dir;
  logic [STEP_W-1:0]   rem;
  logic [DLY_W-1:0]    dly;
  logic [DLY_W-1:0]    dly_rld;

  gray_encoder #(.WIDTH(WIDTH)) u_enc (
    .bin  (bin),
    .gray (gray)
  );

  // Move FSM with dwell/step counters, position register and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      bin         <= '0;
      dir         <= 1'b0;
      rem         <= '0;
      dly         <= '0;
      dly_rld     <= '0;
      step_strobe <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      busy        <= 1'b0;
      cmd_ready   <= 1'b1;
    end else begin
      step_strobe <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      case (state)
        S_IDLE: begin
          // cmd_ready is high whenever we sit in IDLE, so valid alone accepts.
          if (cmd_valid) begin
            dir       <= cmd_dir;
            rem       <= cmd_steps;
            dly       <= cmd_delay;
            dly_rld   <= cmd_delay;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_steps == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (abort) begin
            state   <= S_DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (dly != '0) begin
            dly <= dly - DLY_W'(1);
          end else begin
            bin         <= dir ? bin + WIDTH'(1) : bin - WIDTH'(1);
            step_strobe <= 1'b1;
            rem         <= rem - STEP_W'(1);
            if (rem == STEP_W'(1)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              dly <= dly_rld;
            end
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
